// File: rtl/sop_tracker.sv
// Frame-start tracker: qualifies correlator SOP pulses, gates them with a window
// around the expected boundary, and flywheels a fixed-latency frame SOP once locked.
module sop_tracker #(
    parameter int N_SYMB   = 50,
    parameter int FFTSIZE  = 1024,
    parameter int CPSIZE   = 32,
    parameter int WINDOW   = 20,
    parameter int SPS_NOM  = 20,
    parameter int SPS_TOL  = 5,
    parameter int CONF_MAX = 20,
    parameter int LOCK_UP  = 15,
    parameter int LOCK_DW  = 7,
    parameter int DELAY_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              isop,
    input  logic [14:0]                       n_sps,
    output logic                              osop,
    output logic signed [DELAY_W-1:0]         delay_sop,
    output logic                              found_sync,
    output logic                              sop_frame,
    output logic [1:0]                        state,
    output logic [$clog2(CONF_MAX+1)-1:0]     conf
);

    localparam int L_FRAME = N_SYMB * (FFTSIZE + CPSIZE);
    localparam int PW      = $clog2(L_FRAME);
    localparam int CW      = $clog2(CONF_MAX + 1);

    localparam logic [PW-1:0] P_WIN   = PW'(WINDOW);
    localparam logic [PW-1:0] P_EVAL  = PW'(WINDOW + 1);
    localparam logic [PW-1:0] P_EARLY = PW'(L_FRAME - WINDOW);
    localparam logic [PW-1:0] P_LAST  = PW'(L_FRAME - 1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [PW:0]   L_EXT   = (PW + 1)'(L_FRAME);
    localparam logic [CW-1:0] C_MAX   = CW'(CONF_MAX);
    localparam logic [CW-1:0] C_UP    = CW'(LOCK_UP);
    localparam logic [CW-1:0] C_DW    = CW'(LOCK_DW);
    localparam logic [14:0]   SPS_LO  = 15'(SPS_NOM - SPS_TOL);
    localparam logic [14:0]   SPS_HI  = 15'(SPS_NOM + SPS_TOL);

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        VERIFY   = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    state_t        fsm;
    logic [PW-1:0] pos;
    logic          hit;

    logic          in_search;
    logic          q;
    logic          win;
    logic          realign;
    logic          eval;
    logic [PW:0]   err_raw;
    logic [CW-1:0] conf_new;

    always_comb begin
        in_search = (fsm == SEARCH);
        q         = isop && (n_sps >= SPS_LO) && (n_sps <= SPS_HI);
        win       = !in_search && ((pos <= P_WIN) || (pos >= P_EARLY));
        // With zero confidence any qualified pulse re-anchors the frame, window or not.
        realign   = !in_search && q && ((conf == '0) || (win && !hit));
        eval      = !in_search && (pos == P_EVAL);
        err_raw   = (pos <= P_WIN) ? {1'b0, pos} : ({1'b0, pos} - L_EXT);
        if (hit) begin
            conf_new = (conf == C_MAX) ? conf : conf + 1'b1;
        end else begin
            conf_new = (conf == '0) ? conf : conf - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= SEARCH;
            pos       <= '0;
            conf      <= '0;
            hit       <= 1'b0;
            delay_sop <= '0;
        end else if (in_search) begin
            conf      <= '0;
            delay_sop <= '0;
            hit       <= q;
            pos       <= q ? P_ONE : '0;
            if (q) begin
                fsm <= VERIFY;
            end
        end else if (realign) begin
            pos       <= P_ONE;
            hit       <= 1'b1;
            delay_sop <= win ? err_raw[DELAY_W-1:0] : '0;
        end else begin
            pos <= (pos == P_LAST) ? '0 : pos + 1'b1;
            if (eval) begin
                hit  <= 1'b0;
                conf <= conf_new;
                case (fsm)
                    VERIFY: begin
                        if (!hit && conf == '0) begin
                            fsm       <= SEARCH;
                            pos       <= '0;
                            conf      <= '0;
                            delay_sop <= '0;
                        end else if (conf_new > C_UP) begin
                            fsm <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (!hit) begin
                            fsm <= HOLDOVER;
                        end
                    end
                    HOLDOVER: begin
                        if (hit) begin
                            fsm <= LOCKED;
                        end else if (conf_new < C_DW) begin
                            fsm       <= SEARCH;
                            pos       <= '0;
                            conf      <= '0;
                            delay_sop <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode registered state only; isop/n_sps never reach them directly.
    assign state      = fsm;
    assign found_sync = fsm[1];
    assign sop_frame  = win;
    assign osop       = fsm[1] && (pos == P_EVAL);

endmodule

// File: tb/tb_sop_tracker.sv
// Randomised and directed bench for sop_tracker with a frame-level reference model
// feeding an expected-value queue that a separate monitor drains every cycle.
module tb_sop_tracker;

    localparam int N_SYMB   = 2;
    localparam int FFTSIZE  = 32;
    localparam int CPSIZE   = 8;
    localparam int WINDOW   = 4;
    localparam int SPS_NOM  = 20;
    localparam int SPS_TOL  = 5;
    localparam int CONF_MAX = 6;
    localparam int LOCK_UP  = 4;
    localparam int LOCK_DW  = 2;
    localparam int DELAY_W  = 6;
    localparam int L        = N_SYMB * (FFTSIZE + CPSIZE);
    localparam int EW       = 30;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              isop  = 1'b0;
    logic [14:0]       n_sps = '0;
    logic              osop;
    logic signed [5:0] delay_sop;
    logic              found_sync;
    logic              sop_frame;
    logic [1:0]        state;
    logic [2:0]        conf;

    sop_tracker #(
        .N_SYMB(N_SYMB), .FFTSIZE(FFTSIZE), .CPSIZE(CPSIZE), .WINDOW(WINDOW),
        .SPS_NOM(SPS_NOM), .SPS_TOL(SPS_TOL), .CONF_MAX(CONF_MAX),
        .LOCK_UP(LOCK_UP), .LOCK_DW(LOCK_DW), .DELAY_W(DELAY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .isop(isop), .n_sps(n_sps), .osop(osop),
        .delay_sop(delay_sop), .found_sync(found_sync), .sop_frame(sop_frame),
        .state(state), .conf(conf)
    );

    // clock
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frame position is derived from the cycle of the last anchor
    int m_cyc = 0, m_mode = 0, m_conf = 0, m_hit = 0, m_delay = 0, m_base = 0;

    int first_verify = -2, first_lock = -2, first_osop = -2;
    int first_hold = -2, first_search = -2, osop_count = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int m_pos();
        return (m_mode == 0) ? 0 : (m_cyc - m_base) % L;
    endfunction

    function automatic bit m_win(input int p);
        return (m_mode != 0) && (p <= WINDOW || p >= L - WINDOW);
    endfunction

    task automatic m_clear();
        m_mode = 0; m_conf = 0; m_hit = 0; m_delay = 0; m_base = 0;
    endtask

    task automatic model_step(input bit p_isop, input int p_sps);
        int p, nc;
        bit q, w, h;
        p = m_pos();
        w = m_win(p);
        q = p_isop && (p_sps >= SPS_NOM - SPS_TOL) && (p_sps <= SPS_NOM + SPS_TOL);
        if (m_mode == 0) begin
            if (q) begin
                m_mode = 1; m_base = m_cyc; m_hit = 1; m_delay = 0;
            end
        end else if (q && (m_conf == 0 || (w && m_hit == 0))) begin
            m_base  = m_cyc;
            m_hit   = 1;
            m_delay = !w ? 0 : ((p <= WINDOW) ? p : p - L);
        end else if (p == WINDOW + 1) begin
            h     = (m_hit != 0);
            m_hit = 0;
            nc    = h ? ((m_conf < CONF_MAX) ? m_conf + 1 : CONF_MAX)
                      : ((m_conf > 0) ? m_conf - 1 : 0);
            case (m_mode)
                1: begin
                    if (!h && m_conf == 0) m_clear();
                    else begin
                        m_conf = nc;
                        if (nc > LOCK_UP) m_mode = 2;
                    end
                end
                2: begin
                    m_conf = nc;
                    if (!h) m_mode = 3;
                end
                default: begin
                    if (h) begin m_conf = nc; m_mode = 2; end
                    else if (nc < LOCK_DW) m_clear();
                    else m_conf = nc;
                end
            endcase
        end
        m_cyc++;
        p = m_pos();
        exp_q.push_back({16'(m_cyc), 1'(m_mode >= 2 && p == WINDOW + 1), 1'(m_mode >= 2),
                         m_win(p), 2'(m_mode), 3'(m_conf), 6'(m_delay)});
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic cycle(input bit p, input int s);
        isop  = p;
        n_sps = 15'(s);
        model_step(p, s);
        @(negedge clk);
        isop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, $urandom_range(0, 40));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_osop"}, osop, 0);
        check({tag, "_found_sync"}, found_sync, 0);
        check({tag, "_sop_frame"}, sop_frame, 0);
        check({tag, "_delay_sop"}, delay_sop, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_conf"}, conf, 0);
    endtask

    task automatic acquire(input string tag);
        int t;
        t = m_cyc;
        first_verify = -1; first_lock = -1; first_osop = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) idle(79);
            cycle(1'b1, 20);
        end
        check({tag, "_verify_cycle"}, first_verify - t, 1);
        check({tag, "_lock_cycle"}, first_lock - t, 326);
        check({tag, "_first_osop"}, first_osop - t, 405);
        check({tag, "_conf"}, conf, 6);
    endtask

    // scoreboard monitor: one expected entry per clock, sampled after the edge
    always begin : monitor
        logic [EW-1:0] e;
        int c;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = int'(e[29:14]);
            check("osop", osop, e[13]);
            check("found_sync", found_sync, e[12]);
            check("sop_frame", sop_frame, e[11]);
            check("state", state, e[10:9]);
            check("conf", conf, e[8:6]);
            check("delay_sop", delay_sop, $signed(e[5:0]));
            if (osop) begin
                osop_count++;
                if (first_osop == -1) first_osop = c;
            end
            if (state == 2'd1 && first_verify == -1) first_verify = c;
            if (state == 2'd2 && first_lock == -1) first_lock = c;
            if (state == 2'd3 && first_hold == -1) first_hold = c;
            if (state == 2'd0 && first_search == -1) first_search = c;
        end
    end

    initial begin : stimulus
        int lp, p_cyc, q_cyc, r_cyc, next, pc;
        int rej_sps[5];
        rej_sps = '{10, 26, 14, 0, 0};
        rej_sps[3] = $urandom_range(0, 14);
        rej_sps[4] = $urandom_range(26, 300);

        // reset
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // metric rejection
        osop_count = 0;
        for (int k = 0; k < 5; k++) begin
            idle(79);
            cycle(1'b1, rej_sps[k]);
        end
        idle(10);
        check("reject_state", state, 0);
        check("reject_conf", conf, 0);
        check("reject_osop_count", osop_count, 0);

        acquire("acq1");

        // early pulse at pos 77, then late pulse at pos 2
        lp = m_cyc - 1;
        idle(76);
        first_osop = -1;
        p_cyc = m_cyc;
        cycle(1'b1, 20);
        check("early_delay", delay_sop, -3);
        idle(81);
        check("early_osop_offset", first_osop - p_cyc, 5);
        check("early_anchor", p_cyc - lp, 77);
        q_cyc = m_cyc;
        cycle(1'b1, 25);
        check("late_delay", delay_sop, 2);

        // stray pulse mid-frame and a duplicate inside the window
        idle(39);
        cycle(1'b1, 20);
        check("stray_frame", sop_frame, 0);
        check("stray_delay", delay_sop, 2);
        check("stray_conf", conf, 6);
        check("stray_state", state, 2);
        idle(q_cyc + 80 - m_cyc);
        r_cyc = m_cyc;
        first_osop = -1;
        cycle(1'b1, 20);
        cycle(1'b0, 0);
        cycle(1'b1, 15);
        check("dup_delay", delay_sop, 0);
        idle(4);
        check("dup_osop_offset", first_osop - r_cyc, 5);

        // flywheel through missing pulses until the drop
        first_hold = -1; first_search = -1; osop_count = 0;
        idle(420);
        check("fly_hold_cycle", first_hold - r_cyc, 86);
        check("fly_search_cycle", first_search - r_cyc, 406);
        check("fly_osop_count", osop_count, 5);
        check("fly_found_sync", found_sync, 0);
        check("fly_conf", conf, 0);

        acquire("acq2");

        // asynchronous reset while locked
        idle($urandom_range(1, 70));
        check("pre_reset_state", state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        check("post_reset_state", state, 0);
        acquire("acq3");

        // randomised pulse trains with jitter, drop-outs and stray pulses
        next = m_cyc + $urandom_range(1, 30);
        repeat (2500) begin
            if (m_cyc == next) begin
                pc = m_cyc;
                if ($urandom_range(0, 9) != 0) cycle(1'b1, $urandom_range(12, 28));
                else idle(1);
                next = pc + 74 + $urandom_range(0, 12);
            end else if ($urandom_range(0, 79) == 0) begin
                cycle(1'b1, $urandom_range(0, 40));
            end else begin
                idle(1);
            end
        end
        idle(2);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sop_tracker.md
# sop_tracker

Parametrised frame-start tracker on the Rx path between the cross-correlator peak detector and the OFDM symbol demapper. It qualifies raw start-of-packet pulses by their samples-per-symbol metric and gates them with a timing window around the expected frame boundary. A four-state hysteresis FSM acquires and holds frame lock. A flywheel keeps regenerating a fixed-latency frame SOP through missed correlator peaks, and the block reports the signed timing error of every accepted pulse.

## Interface
- N_SYMB, 50: OFDM symbols per frame
- FFTSIZE, 1024: FFT length in samples
- CPSIZE, 32: cyclic prefix length in samples
- WINDOW, 20: half-width of the acceptance window, in samples
- SPS_NOM, 20: nominal n_sps value for a valid peak
- SPS_TOL, 5: allowed deviation of n_sps from SPS_NOM
- CONF_MAX, 20: confidence counter saturation value
- LOCK_UP, 15: lock is declared when conf > LOCK_UP
- LOCK_DW, 7: lock is dropped when conf < LOCK_DW
- DELAY_W, 6: delay_sop width, must be ≥ clog2(WINDOW+1)+1
- Derived: L_FRAME = N_SYMB*(FFTSIZE+CPSIZE). Required: LOCK_DW < LOCK_UP < CONF_MAX and 2*WINDOW+2 < L_FRAME.

Ports:
- clk  in  1  single clock; every register runs on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- isop  in  1  raw correlator SOP pulse, one cycle wide
- n_sps  in  15  peak metric, valid while isop is high
- osop  out  1  regenerated frame SOP, one cycle wide
- delay_sop  out  DELAY_W  signed timing error of the last accepted pulse
- found_sync  out  1  high in LOCKED and HOLDOVER
- sop_frame  out  1  acceptance window is open (never high in SEARCH)
- state  out  2  SEARCH=0, VERIFY=1, LOCKED=2, HOLDOVER=3
- conf  out  clog2(CONF_MAX+1)  confidence counter

## Operation
- Qualified pulse: q = isop && SPS_NOM−SPS_TOL ≤ n_sps ≤ SPS_NOM+SPS_TOL. When isop is high and q is low, the pulse is ignored in every state.
- pos counts 0..L_FRAME−1 and wraps from L_FRAME−1 to 0.
  - Realignment loads pos←1, so the next pulse is expected at pos=0.
  - In SEARCH, pos is held at 0.
- Window: win = (pos ≤ WINDOW) || (pos ≥ L_FRAME−WINDOW), outside SEARCH. sop_frame = win.
- Timing error of an accepted pulse:
  - err = pos when pos ≤ WINDOW (pulse is late)
  - err = pos − L_FRAME otherwise (pulse is early)
  - err lies in −WINDOW..+WINDOW.
- Pulse acceptance, in priority order:
  - SEARCH with q: go to VERIFY, realign, set hit, delay_sop←0.
  - Non-SEARCH, conf==0, q at any pos: realign, set hit, delay_sop←err if win is high, else 0.
  - Non-SEARCH, q, win high, hit clear: realign, set hit, delay_sop←err.
  - Any other pulse (outside the window, or a second pulse in the same window) is ignored.
- Evaluation happens once per frame at pos==WINDOW+1.
  - hit set: conf+1, saturating at CONF_MAX.
  - hit clear: conf−1, floored at 0.
  - hit is cleared after evaluation.
- FSM transitions, applied at evaluation using the updated conf:
  - VERIFY→LOCKED when conf > LOCK_UP.
  - VERIFY→SEARCH on a miss when conf was already 0.
  - LOCKED→HOLDOVER on a miss.
  - HOLDOVER→LOCKED on a hit.
  - HOLDOVER→SEARCH when conf < LOCK_DW.
- Entering SEARCH clears conf, hit, pos and delay_sop.
- osop = found_sync && pos==WINDOW+1. It is generated every frame in LOCKED and HOLDOVER, including frames with a missed pulse (flywheel).
- If a realign and an evaluation fall on the same cycle, the realign wins: evaluation is skipped and hit is counted at the next evaluation.

## Timing
- Reset (rst_n=0, asynchronous):
  - osop=0, found_sync=0, sop_frame=0, delay_sop=0, state=SEARCH, conf=0, pos=0, hit=0
  - Release of reset is synchronous to clk.
- All outputs are registered or decoded from registers only. There is no combinational path from isop or n_sps to any output.
- Accepted pulse at cycle t:
  - pos=1 and delay_sop updated at t+1
  - evaluation at t+WINDOW+1
  - state and conf updated at t+WINDOW+2
  - osop, when locked, at t+WINDOW+1
- found_sync follows state with zero extra delay.

## Test plan
Parameters for all scenarios: N_SYMB=2, FFTSIZE=32, CPSIZE=8 (L_FRAME=80), WINDOW=4, CONF_MAX=6, LOCK_UP=4, LOCK_DW=2, SPS_NOM=20, SPS_TOL=5.

- Acquisition: isop with n_sps=20 at t, t+80, t+160, … → VERIFY at t+1, conf=5 and state=LOCKED at t+326, first osop at t+405 and then every 80 cycles.
- Metric rejection: periodic isop with n_sps=10 or n_sps=26 → state stays SEARCH, conf=0, osop never asserted.
- Early and late pulse: LOCKED, pulse arrives at pos=77 → delay_sop=−3, osop 5 cycles after the pulse. Next pulse at pos=2 → delay_sop=+2.
- Flywheel and drop: LOCKED with conf=6, pulses stop → HOLDOVER after the first miss, osop continues every 80 cycles, conf=1 after the 5th miss, then SEARCH and found_sync=0.
- Stray pulse: LOCKED, extra qualified pulse at pos=40 and a second pulse inside the window → both ignored, pos, conf and delay_sop unchanged.
- Reset mid-lock: rst_n=0 while LOCKED at arbitrary pos → all outputs 0 before the next clk edge. After release, SEARCH and a fresh acquisition identical to the first scenario.
